// File: rtl/acc_core_pkg.sv
// rtl/acc_core_pkg.sv - opcode and run-state types shared by acc_core and its ALU
package acc_core_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LD  = 4'h1,
    OP_ST  = 4'h2,
    OP_ADD = 4'h3,
    OP_SUB = 4'h4,
    OP_AND = 4'h5,
    OP_OR  = 4'h6,
    OP_XOR = 4'h7,
    OP_NOT = 4'h8,
    OP_LDZ = 4'h9,
    OP_JMP = 4'hA,
    OP_JZ  = 4'hB,
    OP_JC  = 4'hC,
    OP_SHL = 4'hD,
    OP_SHR = 4'hE,
    OP_HLT = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

endpackage

// File: rtl/acc_core_alu.sv
// rtl/acc_core_alu.sv - combinational accumulator ALU; reports which of ACC/CY each opcode writes
module acc_core_alu
  import acc_core_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  opcode_e           op,
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] rn,
  input  logic [DATA_W-1:0] rz,
  output logic [DATA_W-1:0] acc_nxt,
  output logic              acc_we,
  output logic              cy_nxt,
  output logic              cy_we
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  // The extra top bit is the carry for ADD and the borrow for SUB.
  assign sum  = {1'b0, acc} + {1'b0, rn};
  assign diff = {1'b0, acc} - {1'b0, rn};

  always_comb begin
    acc_nxt = acc;
    acc_we  = 1'b0;
    cy_nxt  = 1'b0;
    cy_we   = 1'b0;
    case (op)
      OP_LD:  begin acc_nxt = rn;       acc_we = 1'b1; end
      OP_ADD: begin acc_nxt = sum[DATA_W-1:0];  acc_we = 1'b1; cy_nxt = sum[DATA_W];  cy_we = 1'b1; end
      OP_SUB: begin acc_nxt = diff[DATA_W-1:0]; acc_we = 1'b1; cy_nxt = diff[DATA_W]; cy_we = 1'b1; end
      OP_AND: begin acc_nxt = acc & rn; acc_we = 1'b1; end
      OP_OR:  begin acc_nxt = acc | rn; acc_we = 1'b1; end
      OP_XOR: begin acc_nxt = acc ^ rn; acc_we = 1'b1; end
      OP_NOT: begin acc_nxt = ~acc;     acc_we = 1'b1; end
      OP_LDZ: begin acc_nxt = rz;       acc_we = 1'b1; end
      OP_SHL: begin acc_nxt = {acc[DATA_W-2:0], 1'b0}; acc_we = 1'b1; cy_nxt = acc[DATA_W-1]; cy_we = 1'b1; end
      OP_SHR: begin acc_nxt = {1'b0, acc[DATA_W-1:1]}; acc_we = 1'b1; cy_nxt = acc[0];        cy_we = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/acc_core.sv
// rtl/acc_core.sv - parametrised accumulator core: single-cycle fetch/execute with START/BUSY/DONE control
module acc_core
  import acc_core_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int RA_W   = 2,
  parameter int PC_W   = 5
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              START,
  input  logic [DATA_W-1:0] RZ,
  input  logic [PC_W+3:0]   INSTR,
  output logic [PC_W-1:0]   PC_OUT,
  output logic [DATA_W-1:0] RESULT,
  output logic              CY,
  output logic              BUSY,
  output logic              DONE
);

  localparam int NREG = 2**RA_W;

  state_e            state, state_nxt;
  logic [PC_W-1:0]   pc, pc_nxt;
  logic [DATA_W-1:0] acc;
  logic              cy;
  logic              z;
  logic [DATA_W-1:0] regs [NREG];

  opcode_e           op;
  logic [PC_W-1:0]   operand;
  logic [RA_W-1:0]   n;
  logic [DATA_W-1:0] rn;
  logic [DATA_W-1:0] alu_acc;
  logic              alu_acc_we, alu_cy, alu_cy_we;
  logic              run, launch, taken;

  assign op      = opcode_e'(INSTR[PC_W+3:PC_W]);
  assign operand = INSTR[PC_W-1:0];
  assign n       = operand[RA_W-1:0];
  assign rn      = regs[n];
  assign run     = (state == RUN);

  acc_core_alu #(.DATA_W(DATA_W)) u_alu (
    .op      (op),
    .acc     (acc),
    .rn      (rn),
    .rz      (RZ),
    .acc_nxt (alu_acc),
    .acc_we  (alu_acc_we),
    .cy_nxt  (alu_cy),
    .cy_we   (alu_cy_we)
  );

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    launch    = 1'b0;
    taken     = 1'b0;
    case (state)
      IDLE, HALT: begin
        if (START) begin
          state_nxt = RUN;
          pc_nxt    = '0;
          launch    = 1'b1;
        end
      end
      RUN: begin
        taken = (op == OP_JMP) || ((op == OP_JZ) && z) || ((op == OP_JC) && cy);
        if (op == OP_HLT) begin
          state_nxt = HALT;
        end else if (taken) begin
          pc_nxt = operand;
        end else begin
          pc_nxt = pc + PC_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      pc    <= '0;
      acc   <= '0;
      cy    <= 1'b0;
      z     <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (launch) begin
        acc <= '0;
        cy  <= 1'b0;
        z   <= 1'b0;
      end else if (run) begin
        if (alu_acc_we) begin
          acc <= alu_acc;
          z   <= (alu_acc == '0);
        end
        if (alu_cy_we) cy <= alu_cy;
      end
    end
  end

  // Register file survives HALT and restart; only reset clears it.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (run && (op == OP_ST)) begin
      regs[n] <= acc;
    end
  end

  assign PC_OUT = pc;
  assign RESULT = acc;
  assign CY     = cy;
  assign BUSY   = run;
  assign DONE   = (state == HALT);

endmodule
